// File: rtl/countdown_timer_pkg.sv
// countdown_timer_pkg
//   Shared types for the countdown timer.
//   countdown_state_t : IDLE waits for a load, RUN counts down.
package countdown_timer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } countdown_state_t;

endpackage

// File: rtl/countdown_timer_if.sv
// countdown_timer_if
//   Load handshake bundle for the countdown timer.
//   load_valid  : requester asks to load a start value
//   load_ready  : timer can accept a load (high only while idle)
//   load_value  : start value, sampled when valid && ready
//   master modport drives the request, slave modport is the timer side.
interface countdown_timer_if #(
  parameter int DATA_WIDTH = 8
);

  logic                  load_valid;
  logic                  load_ready;
  logic [DATA_WIDTH-1:0] load_value;

  modport master (
    output load_valid,
    output load_value,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_value,
    output load_ready
  );

endinterface

// File: rtl/countdown_timer.sv
// countdown_timer
//   Loadable down-counter used as a timeout / delay generator. A start value
//   arrives over the load handshake; each enabled cycle subtracts STEP, and a
//   one-cycle done pulse marks the terminal count. The count saturates at zero.
//
//   Parameters:
//     DATA_WIDTH : counter width in bits
//     STEP       : decrement per enabled cycle (1 <= STEP < 2**DATA_WIDTH)
//
//   Ports:
//     clock        : rising-edge clock
//     reset_n      : asynchronous active-low reset
//     load_if      : load handshake (slave side: load_valid/load_value in, load_ready out)
//     count_enable : decrement enable
//     abort        : cancel a running countdown, no done pulse
//     count        : current count, registered
//     busy         : high while in RUN
//     done         : one-cycle terminal-count pulse, registered
//
//   Configuration:
//     COUNTDOWN_TIMER_AUTO_RELOAD_EN : when defined, the terminal event reloads
//     the last accepted start value and stays in RUN; abort is the only way back
//     to IDLE.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int STEP       = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  countdown_timer_if.slave      load_if,
  input  logic                  count_enable,
  input  logic                  abort,
  output logic [DATA_WIDTH-1:0] count,
  output logic                  busy,
  output logic                  done
);

  localparam logic [DATA_WIDTH-1:0] STEP_W = DATA_WIDTH'(STEP);

  countdown_state_t      state_q, state_d;
  logic [DATA_WIDTH-1:0] count_q, count_d;
  logic                  done_q,  done_d;
  logic                  load_accept;

`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
  logic [DATA_WIDTH-1:0] reload_q, reload_d;
`endif

  assign load_if.load_ready = (state_q == IDLE);
  assign load_accept        = load_if.load_valid && (state_q == IDLE);

  assign count = count_q;
  assign busy  = (state_q == RUN);
  assign done  = done_q;

  // Next-state logic. done defaults low so it only pulses on a terminal event;
  // comparing count <= STEP before subtracting keeps the counter from wrapping.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d  = 1'b0;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
    reload_d = reload_q;
`endif

    case (state_q)
      IDLE: begin
        if (load_accept) begin
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
          reload_d = load_if.load_value;
`endif
          if (load_if.load_value != '0) begin
            count_d = load_if.load_value;
            state_d = RUN;
          end else begin
            // A zero load is already at terminal count.
            count_d = '0;
            done_d  = 1'b1;
          end
        end
      end

      RUN: begin
        if (abort) begin
          count_d = '0;
          state_d = IDLE;
        end else if (count_enable) begin
          if (count_q <= STEP_W) begin
            done_d = 1'b1;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
            count_d = reload_q;
`else
            count_d = '0;
            state_d = IDLE;
`endif
          end else begin
            count_d = count_q - STEP_W;
          end
        end
      end

      default: begin
        count_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      count_q <= '0;
      done_q  <= 1'b0;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      done_q  <= done_d;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

endmodule
